// File: rtl/delay_sched_pkg.sv
// Shared types, default constants and arbitration helpers for the delay_sched
// scheduler (shared prescaled delay timer with round-robin ownership).
package delay_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int TICK_DIV_DEF = 3_125_000;
  localparam int LEN_W_DEF    = 8;
  localparam int MAX_REQ      = 8;
  localparam int PTR_W        = 3;

  // First set request at or after ptr, wrapping within nreq; one-hot result.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [PTR_W-1:0]   ptr,
    input int                 nreq
  );
    logic [MAX_REQ-1:0] win;
    logic               found;
    logic [3:0]         pos;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      pos = {1'b0, ptr} + 4'(k);
      if (pos >= 4'(nreq)) pos = pos - 4'(nreq);
      if ((k < nreq) && !found && req[pos[2:0]]) begin
        win[pos[2:0]] = 1'b1;
        found         = 1'b1;
      end
    end
    return win;
  endfunction

  function automatic logic [PTR_W-1:0] oh_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | PTR_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/delay_sched_tick.sv
// Restartable base-tick prescaler: counts 0..TICK_DIV-1 while enabled and
// flags tick on the last count; clr or rst forces the count back to 0.
module delay_tick #(
  parameter int TICK_DIV = 3_125_000,
  parameter int CNT_WDTH = 30
) (
  input  logic dclk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [CNT_WDTH-1:0] LAST = CNT_WDTH'(TICK_DIV - 1);

  logic [CNT_WDTH-1:0] count;

  always_ff @(posedge dclk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/delay_sched.sv
// Round-robin owner of one shared delay timer; grants a requester, times
// len*TICK_DIV cycles, pulses done. Define DELAY_SCHED_ABORT_EN to cancel on req drop.
module delay_sched
  import delay_sched_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int CNT_WDTH = 30,
  parameter int LEN_W    = LEN_W_DEF
) (
  input  logic                  dclk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LEN_W-1:0] len,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output state_t                dbg_state
);

  // Handshake: a requester holds req high until it sees its one-cycle done
  // pulse; grant is one-hot while the requester owns the timer (GRANT..DONE).

  state_t               state;
  logic [NREQ-1:0]      win_q;
  logic [NREQ-1:0]      grant_q;
  logic [NREQ-1:0]      done_q;
  logic                 busy_q;
  logic [PTR_W-1:0]     ptr_q;
  logic [LEN_W-1:0]     cnt_q;

  logic [MAX_REQ-1:0]   req_pad;
  logic [MAX_REQ-1:0]   win_pad;
  logic [MAX_REQ-1:0]   pick;
  logic [PTR_W-1:0]     win_idx;
  logic [PTR_W-1:0]     ptr_next;
  logic [LEN_W-1:0]     len_win;
  logic                 tick;
  logic                 run_en;
  logic                 abort;

  always_comb begin
    req_pad             = '0;
    req_pad[NREQ-1:0]   = req;
    win_pad             = '0;
    win_pad[NREQ-1:0]   = win_q;
    pick                = rr_pick(req_pad, ptr_q, NREQ);
    win_idx             = oh_to_idx(win_pad);
    ptr_next            = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + PTR_W'(1);
    len_win             = len[win_idx*LEN_W +: LEN_W];
  end

`ifdef DELAY_SCHED_ABORT_EN
  assign abort = ~|(req & win_q);
`else
  assign abort = 1'b0;
`endif

  // Prescaler only runs in RUN, so each delay starts from a fresh count.
  assign run_en = (state == RUN);

  delay_tick #(
    .TICK_DIV (TICK_DIV),
    .CNT_WDTH (CNT_WDTH)
  ) u_tick (
    .dclk (dclk),
    .rst  (rst),
    .clr  (!run_en),
    .en   (run_en),
    .tick (tick)
  );

  always_ff @(posedge dclk) begin
    if (rst) begin
      state   <= IDLE;
      win_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= '0;
          cnt_q  <= '0;
          if (|req) begin
            win_q   <= pick[NREQ-1:0];
            grant_q <= pick[NREQ-1:0];
            busy_q  <= 1'b1;
            state   <= GRANT;
          end
        end
        GRANT: begin
          ptr_q <= ptr_next;
          cnt_q <= len_win;
          if (abort) begin
            grant_q <= '0;
            win_q   <= '0;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end else if (len_win == '0) begin
            busy_q <= 1'b0;
            done_q <= win_q;
            state  <= DONE;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            grant_q <= '0;
            win_q   <= '0;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end else if (tick) begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == LEN_W'(1)) begin
              busy_q <= 1'b0;
              done_q <= win_q;
              state  <= DONE;
            end
          end
        end
        DONE: begin
          done_q  <= '0;
          grant_q <= '0;
          win_q   <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign dbg_state = state;

endmodule
